// File: rtl/layer_compositor.sv
// Layer compositor: per-pixel priority resolve across stacked layers, then palette lookup, 2-cycle latency.
// Optional brightness fade on mask change is built when LAYER_COMPOSITOR_FADE_EN is defined.
module layer_compositor #(
    parameter int NUM_LAYERS      = 4,
    parameter int IDX_W           = 4,
    parameter int COLOR_W         = 8,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                                          Clk,
    input  logic                                          Reset_n,
    input  logic                                          frame_start,
    input  logic                                          pix_valid,
    input  logic [NUM_LAYERS*IDX_W-1:0]                   idx_in,
    input  logic [NUM_LAYERS-1:0]                         layer_en_in,
    input  logic                                          pal_we,
    input  logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] pal_layer,
    input  logic [IDX_W-1:0]                              pal_addr,
    input  logic [3*COLOR_W-1:0]                          pal_data,
    output logic [COLOR_W-1:0]                            VGA_R,
    output logic [COLOR_W-1:0]                            VGA_G,
    output logic [COLOR_W-1:0]                            VGA_B,
    output logic                                          out_valid,
    output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] out_layer,
    output logic                                          fade_busy
);

    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CW = 3 * COLOR_W;
    localparam int AW = LW + IDX_W;

    logic [NUM_LAYERS-1:0] mask;
    logic [NUM_LAYERS-1:0] mask_eff;
    logic [LW-1:0]         win_layer;
    logic [IDX_W-1:0]      win_idx;
    logic                  found;
    logic                  s1_valid;
    logic [LW-1:0]         s1_layer;
    logic [IDX_W-1:0]      s1_idx;
    logic                  pal_ok;
    logic [CW-1:0]         pal_mem [2**AW];
    logic [CW-1:0]         rd;
    logic [CW-1:0]         shaded;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mask <= '1;
        end else if (frame_start) begin
            mask <= layer_en_in;
        end
    end

    // Background is forced on so that a fully transparent stack still resolves to it.
    assign mask_eff = mask | {1'b1, {(NUM_LAYERS-1){1'b0}}};

    always_comb begin
        win_layer = LW'(NUM_LAYERS - 1);
        win_idx   = idx_in[(NUM_LAYERS-1)*IDX_W +: IDX_W];
        found     = 1'b0;
        for (int k = 0; k < NUM_LAYERS - 1; k++) begin
            if (!found && mask_eff[k] && idx_in[k*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT_IDX)) begin
                found     = 1'b1;
                win_layer = LW'(k);
                win_idx   = idx_in[k*IDX_W +: IDX_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_layer <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_layer <= win_layer;
            s1_idx   <= win_idx;
        end
    end

    generate
        if ((2**LW) > NUM_LAYERS) begin : g_layer_chk
            assign pal_ok = (pal_layer < LW'(NUM_LAYERS));
        end else begin : g_layer_all
            assign pal_ok = 1'b1;
        end
    endgenerate

    // Palette RAM is not reset; reads see the value before a same-cycle write.
    always_ff @(posedge Clk) begin
        if (pal_we && pal_ok) begin
            pal_mem[{pal_layer, pal_addr}] <= pal_data;
        end
    end

    assign rd = pal_mem[{s1_layer, s1_idx}];

`ifdef LAYER_COMPOSITOR_FADE_EN
    logic [2:0]           fade_level;
    logic [3:0]           fade_mul;
    logic [COLOR_W+2:0]   prod [3];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fade_level <= 3'd7;
        end else if (frame_start) begin
            if (layer_en_in != mask) begin
                fade_level <= 3'd0;
            end else if (fade_level != 3'd7) begin
                fade_level <= fade_level + 3'd1;
            end
        end
    end

    assign fade_mul  = {1'b0, fade_level} + 4'd1;
    assign fade_busy = (fade_level != 3'd7);

    always_comb begin
        shaded = '0;
        for (int c = 0; c < 3; c++) begin
            prod[c] = (COLOR_W+3)'(rd[c*COLOR_W +: COLOR_W]) * (COLOR_W+3)'(fade_mul);
            shaded[c*COLOR_W +: COLOR_W] = COLOR_W'(prod[c] >> 3);
        end
    end
`else
    assign shaded    = rd;
    assign fade_busy = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            out_valid <= 1'b0;
            out_layer <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                VGA_R     <= shaded[2*COLOR_W +: COLOR_W];
                VGA_G     <= shaded[COLOR_W +: COLOR_W];
                VGA_B     <= shaded[0 +: COLOR_W];
                out_layer <= s1_layer;
            end else begin
                VGA_R     <= '0;
                VGA_G     <= '0;
                VGA_B     <= '0;
                out_layer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: a bench-side model predicts each output cycle, a monitor compares.
// Fade expectations follow LAYER_COMPOSITOR_FADE_EN when it is defined.
module tb_layer_compositor;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic        pix_valid;
    logic [15:0] idx_in;
    logic [3:0]  layer_en_in;
    logic        pal_we;
    logic [1:0]  pal_layer;
    logic [3:0]  pal_addr;
    logic [23:0] pal_data;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        out_valid;
    logic [1:0]  out_layer;
    logic        fade_busy;

    layer_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .idx_in(idx_in), .layer_en_in(layer_en_in), .pal_we(pal_we), .pal_layer(pal_layer),
        .pal_addr(pal_addr), .pal_data(pal_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .out_valid(out_valid), .out_layer(out_layer), .fade_busy(fade_busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         due;
        logic       v;
        logic [7:0] r, g, b;
        logic [1:0] layer;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        mon_on = 1'b0;

    logic [23:0] m_pal [4][16];
    logic [3:0]  m_mask;
    int          m_lvl;
    logic        p_have;
    logic        p_valid;
    logic [1:0]  p_layer;
    logic [3:0]  p_idx;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] scale(input logic [7:0] c);
`ifdef LAYER_COMPOSITOR_FADE_EN
        return 8'((int'(c) * (m_lvl + 1)) >> 3);
`else
        return c;
`endif
    endfunction

    function automatic logic model_busy();
`ifdef LAYER_COMPOSITOR_FADE_EN
        return (m_lvl != 7);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge Clk) begin
        if (mon_on && sb.size() > 0) begin
            if (sb[0].due < cyc) begin
                check("sb_late", cyc, sb[0].due);
                void'(sb.pop_front());
            end else if (sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("out_valid", out_valid, e.v);
                check("vga_r", VGA_R, e.r);
                check("vga_g", VGA_G, e.g);
                check("vga_b", VGA_B, e.b);
                check("out_layer", out_layer, e.layer);
            end
        end
    end

    // One pixel clock: finalise the previous pixel's stage-2 prediction, predict this pixel's stage 1, advance.
    task automatic drive(input logic v, input logic [15:0] idx, input logic fs, input logic [3:0] en,
                         input logic we, input logic [1:0] wl, input logic [3:0] wa, input logic [23:0] wd);
        exp_t        e;
        logic [23:0] col;
        logic [3:0]  mk;
        int          w;
        if (p_have) begin
            col     = p_valid ? m_pal[p_layer][p_idx] : 24'h0;
            e.due   = cyc + 1;
            e.v     = p_valid;
            e.r     = p_valid ? scale(col[23:16]) : 8'h0;
            e.g     = p_valid ? scale(col[15:8]) : 8'h0;
            e.b     = p_valid ? scale(col[7:0]) : 8'h0;
            e.layer = p_valid ? p_layer : 2'd0;
            sb.push_back(e);
        end
        mk = m_mask | 4'b1000;
        w  = 3;
        for (int k = 2; k >= 0; k--) begin
            if (mk[k] && idx[k*4 +: 4] != 4'd0) w = k;
        end
        p_have  = 1'b1;
        p_valid = v;
        p_layer = 2'(w);
        p_idx   = idx[w*4 +: 4];

        pix_valid = v; idx_in = idx; frame_start = fs; layer_en_in = en;
        pal_we = we; pal_layer = wl; pal_addr = wa; pal_data = wd;
        @(posedge Clk);
        if (we) m_pal[wl][wa] = wd;
        if (fs) begin
            if (en != m_mask) m_lvl = 0;
            else if (m_lvl < 7) m_lvl = m_lvl + 1;
            m_mask = en;
        end
        #1;
        frame_start = 1'b0;
        pal_we      = 1'b0;
        if (fs) check("fade_busy", fade_busy, model_busy());
    endtask

    task automatic pix(input logic v, input logic [15:0] idx);
        drive(v, idx, 1'b0, 4'hF, 1'b0, 2'd0, 4'd0, 24'h0);
    endtask

    task automatic frame(input logic v, input logic [15:0] idx, input logic [3:0] en);
        drive(v, idx, 1'b1, en, 1'b0, 2'd0, 4'd0, 24'h0);
    endtask

    task automatic wr(input logic v, input logic [15:0] idx, input logic [1:0] l, input logic [3:0] a,
                      input logic [23:0] d);
        drive(v, idx, 1'b0, 4'hF, 1'b1, l, a, d);
    endtask

    initial begin
        Reset_n = 1'b0; pix_valid = 1'b1; idx_in = 16'h2050; frame_start = 1'b0;
        layer_en_in = 4'hF; pal_we = 1'b0; pal_layer = 2'd0; pal_addr = 4'd0; pal_data = 24'h0;
        m_mask = 4'hF; m_lvl = 7; p_have = 1'b0; p_valid = 1'b0; p_layer = 2'd0; p_idx = 4'd0;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_r", VGA_R, 8'h0);
        check("rst_g", VGA_G, 8'h0);
        check("rst_b", VGA_B, 8'h0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_layer", out_layer, 2'd0);
        check("rst_busy", fade_busy, 1'b0);

        @(negedge Clk);
        pix_valid = 1'b0;
        Reset_n   = 1'b1;
        @(posedge Clk);
        #1;
        mon_on = 1'b1;

        wr(1'b0, 16'h0, 2'd1, 4'd5, 24'h102030);
        wr(1'b0, 16'h0, 2'd3, 4'd2, 24'hAABBCC);
        pix(1'b0, 16'h0);

        // priority: layer 1 over background, then background when layer 1 goes transparent
        pix(1'b1, 16'h2050);
        pix(1'b1, 16'h2050);
        pix(1'b1, 16'h2000);
        pix(1'b1, 16'h2000);

        // mask latch: pixel in the frame_start cycle uses the old mask
        frame(1'b1, 16'h2050, 4'b1101);
        pix(1'b1, 16'h2050);
        pix(1'b1, 16'h2050);
        frame(1'b0, 16'h2050, 4'b0000);
        pix(1'b1, 16'h2050);
        pix(1'b1, 16'h2050);

        // read-before-write collision on palette1[5]
        frame(1'b0, 16'h2050, 4'hF);
        pix(1'b1, 16'h2050);
        wr(1'b1, 16'h2050, 2'd1, 4'd5, 24'hFFFFFF);
        pix(1'b1, 16'h2050);

        // blanking gap mid-line
        pix(1'b1, 16'h2050);
        pix(1'b0, 16'h2050);
        pix(1'b0, 16'h2050);
        pix(1'b0, 16'h2050);
        pix(1'b1, 16'h2050);

        // fade ramp on background layer after a mask change
        wr(1'b0, 16'h0, 2'd3, 4'd2, 24'hFFFFFF);
        frame(1'b0, 16'h2050, 4'b1101);
        pix(1'b1, 16'h2050);
        for (int i = 0; i < 7; i++) begin
            frame(1'b0, 16'h2050, 4'b1101);
            pix(1'b1, 16'h2050);
        end
        pix(1'b0, 16'h0);
        pix(1'b0, 16'h0);

        // asynchronous reset in the middle of active video
        frame(1'b1, 16'h2050, 4'hF);
        pix(1'b1, 16'h2050);
        pix(1'b1, 16'h2050);
        mon_on = 1'b0;
        #3;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_r", VGA_R, 8'h0);
        check("mid_rst_g", VGA_G, 8'h0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_layer", out_layer, 2'd0);
        sb.delete();
        p_have = 1'b0;
        m_mask = 4'hF;
        m_lvl  = 7;
        pix_valid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        mon_on = 1'b1;
        pix(1'b0, 16'h0);
        pix(1'b1, 16'h2050);
        pix(1'b1, 16'h2000);
        pix(1'b0, 16'h0);
        pix(1'b0, 16'h0);
        pix(1'b0, 16'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clk);
        @(posedge Clk);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised, pipelined pixel compositor for the VGA path. It takes palette indices for NUM_LAYERS stacked layers: sprites, area maps and the background.
- Per pixel it selects the highest-priority visible layer and looks the colour up in that layer's writable palette RAM. It drives registered VGA_R/G/B with a fixed 2-cycle latency.
- It sits between the per-layer sprite/map index ROMs and the VGA controller.

Parameters:
- NUM_LAYERS, 4: number of layers; layer 0 has highest priority, layer NUM_LAYERS-1 is the background.
- IDX_W, 4: palette index width per layer; each palette has 2**IDX_W entries.
- COLOR_W, 8: width of each colour channel.
- TRANSPARENT_IDX, 0: index treated as transparent on every layer except the background.

Ports:
- Clk  in  1  system clock (pixel clock domain).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- pix_valid  in  1  idx_in is valid this cycle (active video).
- idx_in  in  NUM_LAYERS*IDX_W  layer k index at bits [k*IDX_W +: IDX_W].
- layer_en_in  in  NUM_LAYERS  requested layer-enable mask; latched at frame_start.
- pal_we  in  1  palette write strobe.
- pal_layer  in  max(1,$clog2(NUM_LAYERS))  palette being written.
- pal_addr  in  IDX_W  palette entry being written.
- pal_data  in  3*COLOR_W  {R,G,B} write data.
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  registered colour.
- out_valid  out  1  pix_valid delayed by 2 cycles.
- out_layer  out  max(1,$clog2(NUM_LAYERS))  layer that won the current output pixel.
- fade_busy  out  1  fade ramp in progress.

Behaviour:
- Reset (Reset_n=0, asynchronous): all pipeline registers clear.
  - VGA_R/G/B=0, out_valid=0, out_layer=0, fade_busy=0.
  - Active enable mask = all ones.
  - Palette contents are not reset; bench must write them before use.
- Enable mask latching:
  - Active mask loads from layer_en_in on the cycle after frame_start is sampled high.
  - A pixel presented in the frame_start cycle uses the old mask.
  - The background layer is always treated as enabled, regardless of its mask bit.
- Stage 1 (priority resolve, registered):
  - Winner = lowest k with mask[k]=1 and idx_k != TRANSPARENT_IDX.
  - If no such k, winner = NUM_LAYERS-1; the background index is used as-is, even if it equals TRANSPARENT_IDX.
  - Registers winner, winner index and pix_valid.
- Stage 2 (palette read, registered output):
  - Reads palette[winner][index] and registers the result into VGA_R/G/B.
  - Also registers out_layer and out_valid.
  - When the stage-2 valid is 0, VGA_R/G/B and out_layer register as 0 (blanking).
- Latency: exactly 2 cycles from pix_valid/idx_in to out_valid/colour. Throughput is one pixel per clock with no stalls.
- Palette write:
  - Takes effect at the clock edge with pal_we=1.
  - A read of the same entry in the same cycle returns the old value (read-before-write).
  - pal_layer >= NUM_LAYERS: write is ignored.
  - Writes are legal at any time, including active video.
- Reset mid-frame: outputs go to 0 immediately. The pipeline restarts empty, so the first out_valid comes 2 cycles after the first pix_valid following release.

Optional Feature:
- Macro: LAYER_COMPOSITOR_FADE_EN.
- Defined:
  - A 3-bit fade_level register (reset 7) drives the fade.
  - On any frame_start where the newly latched mask differs from the previous one, fade_level loads 0 and fade_busy goes 1.
  - On each later frame_start, fade_level increments, saturating at 7; fade_busy=0 once it reaches 7.
  - Output channel = (palette_channel * (fade_level+1)) >> 3, computed before the stage-2 register, so latency stays 2.
  - A mask change during a fade restarts the ramp at 0.
- Undefined:
  - No fade logic is built; fade_busy is tied 0.
  - Colours pass through at full intensity.

Test Plan:
- Reset: hold Reset_n=0 with pix_valid=1 -> VGA_R/G/B=0, out_valid=0, fade_busy=0; release -> first out_valid exactly 2 cycles after the first sampled pix_valid.
- Priority:
  - Write palette1[5]={8'h10,8'h20,8'h30} and palette3[2]={8'hAA,8'hBB,8'hCC}.
  - Drive idx0=0, idx1=5, idx2=0, idx3=2 -> after 2 cycles RGB=10/20/30, out_layer=1.
  - Set idx1=0 -> RGB=AA/BB/CC, out_layer=3.
- Mask latch:
  - Pulse frame_start with layer_en_in=4'b1101 while idx1=5 -> the pixel in the pulse cycle still shows layer 1.
  - From the next pixel on, layer 3 is shown.
  - Mask 4'b0000 still shows layer 3.
- Write/read collision:
  - Read palette1[5] while writing it to 8'hFF each channel -> that pixel outputs the old 10/20/30.
  - The following pixel outputs FF/FF/FF.
- Blanking: pix_valid=0 for 3 cycles mid-line -> out_valid=0 and RGB=0 for exactly those 3 output cycles, 2 cycles delayed.
- Fade (FADE_EN builds only):
  - Change the mask at frame_start -> fade_busy=1 and channel 8'hFF outputs 8'h1F.
  - Over subsequent frames it steps 3F, 5F, 7F, 9F, BF, DF, FF; fade_busy drops at the final step.
